// File: rtl/rom_access_seq.sv
// SRAM0 cycle sequencer: SNES reads/writes take priority, MCU accesses fill idle bus slots.
// Optional feature: define MCU_BURST_EN to chain sequential MCU reads from RECOV directly into MRD.
module rom_access_seq #(
  parameter int unsigned RD_WAIT  = 4,
  parameter int unsigned WR_WAIT  = 4,
  parameter int unsigned MAX_PEND = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_RD_start,
  input  logic        SNES_WR_start,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        SNES_DATA_VALID,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_DATA_IN,
  output logic [7:0]  MCU_DATA_OUT,
  output logic        MCU_RDY,
  output logic [23:0] MEM_ADDR,
  input  logic [7:0]  MEM_DQ_IN,
  output logic [7:0]  MEM_DQ_OUT,
  output logic        MEM_DQ_OE,
  output logic        MEM_CE_N,
  output logic        MEM_OE_N,
  output logic        MEM_WE_N
);

  typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, RECOV} state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [23:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic [7:0]  snes_out_q, snes_out_d;
  logic        snes_vld_q, snes_vld_d;
  logic [7:0]  mcu_out_q, mcu_out_d;
  logic        mcu_rdy_q, mcu_rdy_d;
`ifdef MCU_BURST_EN
  logic        last_mrd_q, last_mrd_d;
`endif

  // Start decode: a read wins over a simultaneous write; misses and read-only writes are dropped.
  logic snes_rd_ok, snes_wr_ok, snes_ok;
  assign snes_rd_ok = SNES_RD_start & ROM_HIT;
  assign snes_wr_ok = SNES_WR_start & ROM_HIT & IS_WRITABLE & ~SNES_RD_start;
  assign snes_ok    = snes_rd_ok | snes_wr_ok;

  logic        go;
  state_t      go_state;
  logic [23:0] go_addr;
  logic [7:0]  go_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    dq_oe_d     = dq_oe_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    snes_out_d  = snes_out_q;
    snes_vld_d  = 1'b0;
    mcu_out_d   = mcu_out_q;
    mcu_rdy_d   = mcu_rdy_q;
`ifdef MCU_BURST_EN
    last_mrd_d  = last_mrd_q;
`endif
    go       = 1'b0;
    go_state = IDLE;
    go_addr  = '0;
    go_data  = '0;

    if (snes_ok && state_q != IDLE && state_q != RECOV) begin
      pend_d      = 1'b1;
      pend_wr_d   = snes_wr_ok;
      pend_addr_d = ROM_ADDR;
      pend_data_d = SNES_DATA_IN;
    end

    case (state_q)
      IDLE: begin
        if (snes_ok) begin
          go       = 1'b1;
          go_state = snes_wr_ok ? SWR : SRD;
          go_addr  = ROM_ADDR;
          go_data  = SNES_DATA_IN;
        end else if (MCU_RRQ) begin
          go        = 1'b1;
          go_state  = MRD;
          go_addr   = MCU_ADDR;
          mcu_rdy_d = 1'b0;
        end else if (MCU_WRQ) begin
          go        = 1'b1;
          go_state  = MWR;
          go_addr   = MCU_ADDR;
          go_data   = MCU_DATA_IN;
          mcu_rdy_d = 1'b0;
        end
      end
      SRD, MRD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == RD_LAST) begin
          state_d = RECOV;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (state_q == SRD) begin
            snes_out_d = MEM_DQ_IN;
            snes_vld_d = 1'b1;
          end else begin
            mcu_out_d = MEM_DQ_IN;
            mcu_rdy_d = 1'b1;
          end
`ifdef MCU_BURST_EN
          last_mrd_d = (state_q == MRD);
`endif
        end
      end
      SWR, MWR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WR_LAST) begin
          state_d = RECOV;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (state_q == MWR) mcu_rdy_d = 1'b1;
`ifdef MCU_BURST_EN
          last_mrd_d = 1'b0;
`endif
        end
      end
      RECOV: begin
        // Write data stays driven through this cycle and is released at its end.
        state_d = IDLE;
        dq_oe_d = 1'b0;
        pend_d  = 1'b0;
        if (snes_ok) begin
          go       = 1'b1;
          go_state = snes_wr_ok ? SWR : SRD;
          go_addr  = ROM_ADDR;
          go_data  = SNES_DATA_IN;
        end else if (pend_q) begin
          go       = 1'b1;
          go_state = pend_wr_q ? SWR : SRD;
          go_addr  = pend_addr_q;
          go_data  = pend_data_q;
        end
`ifdef MCU_BURST_EN
        else if (last_mrd_q && MCU_RRQ && MCU_ADDR == addr_q + 24'd1) begin
          go        = 1'b1;
          go_state  = MRD;
          go_addr   = MCU_ADDR;
          mcu_rdy_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d = go_state;
      cnt_d   = 4'd0;
      addr_d  = go_addr;
      ce_n_d  = 1'b0;
      if (go_state == SRD || go_state == MRD) begin
        oe_n_d  = 1'b0;
        dq_oe_d = 1'b0;
      end else begin
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = go_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      snes_out_q  <= '0;
      snes_vld_q  <= 1'b0;
      mcu_out_q   <= '0;
      mcu_rdy_q   <= 1'b1;
`ifdef MCU_BURST_EN
      last_mrd_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      snes_out_q  <= snes_out_d;
      snes_vld_q  <= snes_vld_d;
      mcu_out_q   <= mcu_out_d;
      mcu_rdy_q   <= mcu_rdy_d;
`ifdef MCU_BURST_EN
      last_mrd_q  <= last_mrd_d;
`endif
    end
  end

`ifndef SYNTHESIS
  // Only one SNES request can wait; a second start before service is an illegal SNES timing.
  always @(posedge CLK) begin
    if (RST_N) begin
      assert (!(pend_q && snes_ok))
        else $warning("rom_access_seq: SNES start overwrote a pending request");
      assert (MAX_PEND == 1)
        else $error("rom_access_seq: only one pending SNES request is supported");
    end
  end
`endif

  assign SNES_DATA_OUT   = snes_out_q;
  assign SNES_DATA_VALID = snes_vld_q;
  assign MCU_DATA_OUT    = mcu_out_q;
  assign MCU_RDY         = mcu_rdy_q;
  assign MEM_ADDR        = addr_q;
  assign MEM_DQ_OUT      = dq_out_q;
  assign MEM_DQ_OE       = dq_oe_q;
  assign MEM_CE_N        = ce_n_q;
  assign MEM_OE_N        = oe_n_q;
  assign MEM_WE_N        = we_n_q;

endmodule

// File: tb/tb_rom_access_seq.sv
// Bench for rom_access_seq: a per-cycle bus schedule model built from access timing rules,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_rom_access_seq;
  localparam int RD_WAIT = 4;
  localparam int WR_WAIT = 4;
  localparam int N       = 4000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SNES_RD_start, SNES_WR_start, ROM_HIT, IS_WRITABLE;
  logic [23:0] ROM_ADDR, MCU_ADDR, MEM_ADDR;
  logic [7:0]  SNES_DATA_IN, SNES_DATA_OUT, MCU_DATA_IN, MCU_DATA_OUT, MEM_DQ_IN, MEM_DQ_OUT;
  logic        SNES_DATA_VALID, MCU_RRQ, MCU_WRQ, MCU_RDY;
  logic        MEM_DQ_OE, MEM_CE_N, MEM_OE_N, MEM_WE_N;

  always #5 CLK = ~CLK;

  rom_access_seq #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .MAX_PEND(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SNES_RD_start(SNES_RD_start), .SNES_WR_start(SNES_WR_start),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
    .SNES_DATA_IN(SNES_DATA_IN), .SNES_DATA_OUT(SNES_DATA_OUT), .SNES_DATA_VALID(SNES_DATA_VALID),
    .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR), .MCU_DATA_IN(MCU_DATA_IN),
    .MCU_DATA_OUT(MCU_DATA_OUT), .MCU_RDY(MCU_RDY),
    .MEM_ADDR(MEM_ADDR), .MEM_DQ_IN(MEM_DQ_IN), .MEM_DQ_OUT(MEM_DQ_OUT), .MEM_DQ_OE(MEM_DQ_OE),
    .MEM_CE_N(MEM_CE_N), .MEM_OE_N(MEM_OE_N), .MEM_WE_N(MEM_WE_N)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Expected bus picture per cycle index
  logic        e_ce_n [N];
  logic        e_oe_n [N];
  logic        e_we_n [N];
  logic        e_dq_oe[N];
  logic        e_vld  [N];
  logic        e_rdy  [N];
  logic        e_rst  [N];
  logic        e_mchk [N];
  logic [23:0] e_addr [N];
  logic [7:0]  e_dqo  [N];
  logic [7:0]  e_sdat [N];
  logic [7:0]  e_mdat [N];
  logic [7:0]  mem_in [N];

  int          busy_until = 0;   // last cycle (RECOV) of the latest scheduled access
  int          last_begin = 0;   // first cycle of the latest scheduled access
  bit          last_mrd   = 1'b0;
  logic [23:0] last_addr  = '0;
  bit          snes_took  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endfunction

  function automatic void set_def(int k);
    e_ce_n[k] = 1'b1; e_oe_n[k] = 1'b1; e_we_n[k] = 1'b1; e_dq_oe[k] = 1'b0;
    e_vld[k] = 1'b0; e_rdy[k] = 1'b1; e_rst[k] = 1'b0; e_mchk[k] = 1'b0;
    e_addr[k] = '0; e_dqo[k] = '0; e_sdat[k] = '0; e_mdat[k] = '0;
  endfunction

  // One access occupies w active cycles starting at b, then one recovery cycle.
  function automatic void sched(bit is_wr, bit is_mcu, int b, logic [23:0] a, logic [7:0] d);
    int w = is_wr ? WR_WAIT : RD_WAIT;
    for (int k = b; k < b + w; k++) begin
      e_ce_n[k] = 1'b0;
      e_addr[k] = a;
      if (is_wr) begin e_we_n[k] = 1'b0; e_dq_oe[k] = 1'b1; e_dqo[k] = d; end
      else e_oe_n[k] = 1'b0;
      if (is_mcu) e_rdy[k] = 1'b0;
    end
    if (is_wr) begin e_dq_oe[b+w] = 1'b1; e_dqo[b+w] = d; end
    else if (is_mcu) begin e_mchk[b+w] = 1'b1; e_mdat[b+w] = mem_in[b+w-1]; end
    else begin e_vld[b+w] = 1'b1; e_sdat[b+w] = mem_in[b+w-1]; end
    busy_until = b + w;
    last_begin = b;
    last_mrd   = is_mcu && !is_wr;
    last_addr  = a;
  endfunction

  function automatic void model_rst(int c);
    for (int k = c + 1; k < c + 40 && k < N; k++) set_def(k);
    e_rst[c+1] = 1'b1;
    busy_until = c;
    last_begin = c;
    last_mrd   = 1'b0;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
    cyc++;
    SNES_RD_start = 1'b0; SNES_WR_start = 1'b0; MCU_RRQ = 1'b0; MCU_WRQ = 1'b0;
    snes_took = 1'b0;
    ROM_ADDR = 24'($urandom); ROM_HIT = 1'($urandom); IS_WRITABLE = 1'($urandom);
    SNES_DATA_IN = 8'($urandom); MCU_ADDR = 24'($urandom); MCU_DATA_IN = 8'($urandom);
    MEM_DQ_IN = mem_in[cyc];
  endtask

  task automatic snes(bit rd, bit wr, bit hit, bit wrt, logic [23:0] a, logic [7:0] d);
    SNES_RD_start = rd; SNES_WR_start = wr; ROM_HIT = hit; IS_WRITABLE = wrt;
    ROM_ADDR = a; SNES_DATA_IN = d;
    if (hit && (rd || (wr && wrt))) begin
      snes_took = 1'b1;
      sched(!rd, 1'b0, (cyc > busy_until) ? cyc + 1 : busy_until + 1, a, d);
    end
  endtask

  task automatic mcu(bit rd, bit wr, logic [23:0] a, logic [7:0] d);
    logic [23:0] nxt;
    MCU_RRQ = rd; MCU_WRQ = wr; MCU_ADDR = a; MCU_DATA_IN = d;
    nxt = last_addr + 24'd1;
    if (!snes_took && (rd || wr)) begin
      if (cyc > busy_until) sched(!rd, 1'b1, cyc + 1, a, d);
`ifdef MCU_BURST_EN
      else if (rd && cyc == busy_until && last_mrd && a == nxt) sched(1'b0, 1'b1, cyc + 1, a, d);
`endif
    end
  endtask

  task automatic do_reset(int n);
    RST_N = 1'b0;
    for (int i = 0; i < n; i++) begin
      model_rst(cyc);
      tick();
    end
    RST_N = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (cyc >= 1 && cyc < N) begin
      chk("ce_n", MEM_CE_N, e_ce_n[cyc]);
      chk("oe_n", MEM_OE_N, e_oe_n[cyc]);
      chk("we_n", MEM_WE_N, e_we_n[cyc]);
      chk("dq_oe", MEM_DQ_OE, e_dq_oe[cyc]);
      chk("snes_valid", SNES_DATA_VALID, e_vld[cyc]);
      chk("mcu_rdy", MCU_RDY, e_rdy[cyc]);
      if (!e_ce_n[cyc]) chk("mem_addr", MEM_ADDR, e_addr[cyc]);
      if (e_dq_oe[cyc]) chk("mem_dq_out", MEM_DQ_OUT, e_dqo[cyc]);
      if (e_vld[cyc]) chk("snes_data", SNES_DATA_OUT, e_sdat[cyc]);
      if (e_mchk[cyc]) chk("mcu_data", MCU_DATA_OUT, e_mdat[cyc]);
      if (e_rst[cyc]) begin
        chk("rst_mem_addr", MEM_ADDR, 24'h0);
        chk("rst_dq_out", MEM_DQ_OUT, 8'h0);
        chk("rst_snes_data", SNES_DATA_OUT, 8'h0);
        chk("rst_mcu_data", MCU_DATA_OUT, 8'h0);
      end
    end
  end

  initial begin
    int s, m, vcyc, oe_cnt, lat, last_oe, next_oe;
    logic [7:0] vdat;
    bit flag_a, flag_b;
    logic [23:0] a2;

    for (int k = 0; k < N; k++) begin
      set_def(k);
      mem_in[k] = 8'($urandom);
    end
    RST_N = 1'b0;
    SNES_RD_start = 1'b0; SNES_WR_start = 1'b0; MCU_RRQ = 1'b0; MCU_WRQ = 1'b0;
    ROM_ADDR = '0; ROM_HIT = 1'b0; IS_WRITABLE = 1'b0; SNES_DATA_IN = '0;
    MCU_ADDR = '0; MCU_DATA_IN = '0; MEM_DQ_IN = mem_in[0];
    do_reset(3);
    tick();
    chk("reset_rdy", MCU_RDY, 1'b1);

    // Idle SNES read at C00123 with 5A on the bus
    for (int k = cyc + 1; k < cyc + 12; k++) mem_in[k] = 8'h5A;
    s = cyc;
    snes(1'b1, 1'b0, 1'b1, 1'b1, 24'hC00123, 8'h00);
    chk("t1_model_valid_at_5", e_vld[s+5], 1'b1);
    oe_cnt = 0; vcyc = -1; vdat = '0; flag_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!MEM_OE_N) begin oe_cnt++; if (MEM_ADDR != 24'hC00123) flag_a = 1'b0; end
      if (SNES_DATA_VALID && vcyc < 0) begin vcyc = cyc; vdat = SNES_DATA_OUT; end
    end
    chk("t1_oe_cycles", oe_cnt, 4);
    chk("t1_latency", vcyc - s, 5);
    chk("t1_data", vdat, 8'h5A);
    chk("t1_addr", flag_a, 1'b1);

    // Write to a non-writable area
    snes(1'b0, 1'b1, 1'b1, 1'b0, 24'h123456, 8'h77);
    flag_a = 1'b0; flag_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!MEM_WE_N) flag_a = 1'b1;
      if (!MEM_CE_N) flag_b = 1'b1;
    end
    chk("t2_we_stays_high", flag_a, 1'b0);
    chk("t2_no_cycle", flag_b, 1'b0);

    // SNES read one cycle into an MCU write
    mcu(1'b0, 1'b1, 24'h001234, 8'hA5);
    tick();
    s = cyc;
    snes(1'b1, 1'b0, 1'b1, 1'b1, 24'h400000, 8'h00);
    chk("t3_model_valid_at_9", e_vld[s+9], 1'b1);
    vcyc = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (SNES_DATA_VALID && vcyc < 0) vcyc = cyc;
    end
    lat = vcyc - s;
    chk("t3_within_bound", (vcyc > 0 && lat <= 12), 1'b1);

    // Simultaneous SNES read and MCU read in IDLE
    snes(1'b1, 1'b0, 1'b1, 1'b1, 24'h800010, 8'h00);
    mcu(1'b1, 1'b0, 24'h000020, 8'h00);
    flag_a = 1'b0; flag_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!MCU_RDY) flag_a = 1'b1;
      if (SNES_DATA_VALID) flag_b = 1'b1;
    end
    chk("t4_rdy_stays_high", flag_a, 1'b0);
    chk("t4_snes_served", flag_b, 1'b1);

    // Reset in the middle of an SNES read
    snes(1'b1, 1'b0, 1'b1, 1'b1, 24'hC00200, 8'h00);
    tick();
    tick();
    do_reset(1);
    chk("t5_ce_high", MEM_CE_N, 1'b1);
    chk("t5_oe_high", MEM_OE_N, 1'b1);
    chk("t5_we_high", MEM_WE_N, 1'b1);
    flag_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (SNES_DATA_VALID) flag_a = 1'b1;
      tick();
    end
    chk("t5_no_valid", flag_a, 1'b0);

    // Sequential MCU reads FFFFFF then 000000
    last_oe = -1; next_oe = -1; a2 = '1;
    mcu(1'b1, 1'b0, 24'hFFFFFF, 8'h00);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!MEM_OE_N) last_oe = cyc;
      if (MCU_RDY) break;
    end
    mcu(1'b1, 1'b0, 24'h000000, 8'h00);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!MEM_OE_N) begin next_oe = cyc; a2 = MEM_ADDR; break; end
      if (MCU_RDY) mcu(1'b1, 1'b0, 24'h000000, 8'h00);
    end
`ifdef MCU_BURST_EN
    chk("t6_gap", next_oe - last_oe, 2);
`else
    chk("t6_gap", next_oe - last_oe, 3);
`endif
    chk("t6_addr", a2, 24'h000000);
    for (int k = 0; k < 10; k++) tick();

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if (last_begin <= cyc && $urandom_range(0, 4) == 0) begin
        int r = $urandom_range(0, 9);
        snes(r < 5 || r == 9, r >= 5, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
             24'($urandom), 8'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        logic [23:0] ma;
        int r2 = $urandom_range(0, 9);
        ma = ($urandom_range(0, 1) == 1) ? last_addr + 24'd1 : 24'($urandom);
        mcu(r2 < 6 || r2 == 9, r2 >= 6, ma, 8'($urandom));
      end
      tick();
    end
    for (int k = 0; k < 30; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
